// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder: valid/ready request and response channels with a
// fixed number of wait states between accepting a request and committing the access.
module mips_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic          accept, commit;
    logic          acc_we;
    logic [31:0]   acc_addr, acc_wdata;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;

    // Commit only happens from IDLE when there are no wait states, so the live request
    // is used there; otherwise the copy captured at acceptance is used.
    assign acc_we    = (state == S_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
    assign in_range  = (acc_addr < DEPTH_W);
    assign idx       = acc_addr[AW-1:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rsp_err   <= !in_range;
                rsp_rdata <= (in_range && !acc_we) ? mem[idx] : 32'd0;
            end
        end
    end

    // NOTE: the array has no reset; reset only suppresses a write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_we && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the memory array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between request acceptance and data commit (legal range 0-15).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr  input  32  word address (not byte address).
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response is available.
REQ-011 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-012 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  address out of range (req_addr >= DEPTH).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL accept a request on an edge where req_valid && req_ready, capturing req_we, req_addr and req_wdata into internal registers; later input changes are ignored.
REQ-017 SHALL on acceptance go to WAIT with the wait counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise go directly to RESP.
REQ-018 SHALL decrement the counter each cycle in WAIT and go to RESP on the edge where it reads 0.
REQ-019 SHALL perform the memory access on the edge entering RESP: loads register Mem[addr] into rsp_rdata; stores write Mem[addr] and set rsp_rdata=0.
REQ-020 SHALL assert rsp_valid exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-021 SHALL, for req_addr >= DEPTH, skip the memory access, set rsp_err=1 and rsp_rdata=0; otherwise rsp_err=0.
REQ-022 SHALL compare the full 32-bit req_addr for the range check; no address wrap or aliasing.
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-024 SHALL assert req_ready in the cycle after the response handshake; maximum throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-025 SHALL ignore req_valid outside IDLE, with no queuing.
REQ-026 SHALL ignore rsp_ready outside RESP.
REQ-027 SHALL return, for a load of an address stored earlier, the most recently stored word; the memory array itself is not reset.

Reset
REQ-028 SHALL on reset=1 at a clock edge force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after that edge.
REQ-029 SHALL drop any transaction in WAIT on reset, with no memory write performed; a store already committed in RESP remains in memory.
REQ-030 SHALL give reset priority over every handshake on the same edge.

Verification
REQ-031 SHALL cover: WAIT_CYCLES=2, store addr 5 data 32'hDEADBEEF, then load addr 5 -> load rsp_valid 3 edges after acceptance, rsp_rdata=32'hDEADBEEF, rsp_err=0.
REQ-032 SHALL cover: load addr 1024 (DEPTH=1024) -> rsp_err=1, rsp_rdata=0; store addr 32'hFFFFFFFF -> rsp_err=1 and no array word changed.
REQ-033 SHALL cover: rsp_ready held 0 for 4 cycles after rsp_valid -> outputs stable, req_ready=0, a new req_valid is ignored; rsp_ready=1 -> IDLE, and req_ready=1 in the next cycle.
REQ-034 SHALL cover: WAIT_CYCLES=0, load addr 0 after a store of 32'h12345678 -> rsp_valid 1 edge after acceptance with rsp_rdata=32'h12345678.
REQ-035 SHALL cover: reset asserted during WAIT of a store addr 7 data 32'h1 (addr 7 previously 32'hA5) -> state IDLE, rsp_valid=0; a subsequent load of addr 7 returns 32'hA5.
REQ-036 SHALL cover: input changes to req_addr/req_wdata during WAIT -> response reflects the values captured at acceptance.
